// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared FSM state encoding for the serial arithmetic blocks
package serial_subtractor_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// rtl/serial_subtractor_full_subtractor.sv - one-bit combinational full subtractor cell
module full_subtractor
(
   input  logic x,
   input  logic y,
   input  logic b_in,
   output logic d,
   output logic b_out
);

   always @(*) begin
      d     = x ^ y ^ b_in;
      b_out = (~x & y) | (~(x ^ y) & b_in);
   end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial N-bit subtractor, LSB first, one full-subtractor cell
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int N = 8
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] diff,
   output logic         borrow,
   output logic         ovf
);

   localparam int CW = $clog2(N);

   logic [1:0]    r_state;
   logic [N-1:0]  r_a_sh;
   logic [N-1:0]  r_b_sh;
   logic [N-1:0]  r_res;
   logic          r_bff;
   logic          r_a_msb;
   logic          r_b_msb;
   logic [CW-1:0] r_cnt;
   logic          r_done;
   logic [N-1:0]  r_diff;
   logic          r_borrow;
   logic          r_ovf;

   logic          w_d;
   logic          w_bo;
   logic          w_accept;

   full_subtractor u_cell (
      .x     (r_a_sh[0]),
      .y     (r_b_sh[0]),
      .b_in  (r_bff),
      .d     (w_d),
      .b_out (w_bo)
   );

   // DONE is not busy, so a start there chains straight into the next operation
   assign w_accept = start && (r_state != S_SHIFT);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_res    <= '0;
         r_bff    <= 1'b0;
         r_a_msb  <= 1'b0;
         r_b_msb  <= 1'b0;
         r_cnt    <= '0;
         r_done   <= 1'b0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_SHIFT: begin
               r_res  <= {w_d, r_res[N-1:1]};
               r_a_sh <= {1'b0, r_a_sh[N-1:1]};
               r_b_sh <= {1'b0, r_b_sh[N-1:1]};
               r_bff  <= w_bo;
               if (r_cnt == CW'(N-1)) begin
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_DONE: begin
               r_done   <= 1'b1;
               r_diff   <= r_res;
               r_borrow <= r_bff;
               r_ovf    <= (r_a_msb != r_b_msb) && (r_res[N-1] != r_a_msb);
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
         if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_a_msb <= a[N-1];
            r_b_msb <= b[N-1];
            r_bff   <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
         end
      end
   end

   assign busy   = (r_state == S_SHIFT);
   assign done   = r_done;
   assign diff   = r_diff;
   assign borrow = r_borrow;
   assign ovf    = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized self-checking bench for serial_subtractor
module tb_serial_subtractor;

   localparam int N = 8;
   localparam int NPAIRS = 1500;

   logic         clk;
   logic         rst;
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic [N-1:0] diff;
   logic         borrow;
   logic         ovf;

   int n_checks;
   int n_errors;

   serial_subtractor #(.N(N)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow),
      .ovf    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer arithmetic on the operand values
   function automatic logic [N-1:0] ref_diff(input logic [N-1:0] x, input logic [N-1:0] y);
      int d;
      d = (int'(x) - int'(y)) & ((1 << N) - 1);
      return d[N-1:0];
   endfunction

   function automatic logic ref_borrow(input logic [N-1:0] x, input logic [N-1:0] y);
      return int'(x) < int'(y);
   endfunction

   function automatic logic ref_ovf(input logic [N-1:0] x, input logic [N-1:0] y);
      int sx, sy, d;
      sx = x[N-1] ? int'(x) - (1 << N) : int'(x);
      sy = y[N-1] ? int'(y) - (1 << N) : int'(y);
      d  = sx - sy;
      return (d > (1 << (N-1)) - 1) || (d < -(1 << (N-1)));
   endfunction

   task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv,
                         input logic [N-1:0] ed, input logic eb, input logic eo);
      int cyc;
      a = av;
      b = bv;
      start = 1'b1;
      tick();
      start = 1'b0;
      a = N'($urandom);
      b = N'($urandom);
      check("busy_after_start", 32'(busy), 32'd1);
      cyc = 0;
      while (!done && cyc < 20) begin
         tick();
         cyc++;
      end
      check("latency", cyc, 9);
      check("diff", 32'(diff), 32'(ed));
      check("borrow", 32'(borrow), 32'(eb));
      check("ovf", 32'(ovf), 32'(eo));
      tick();
      check("done_one_cycle", 32'(done), 32'd0);
   endtask

   logic [N-1:0] pa [NPAIRS];
   logic [N-1:0] pb [NPAIRS];
   int           q[$];

   initial begin
      int ndone, cur, got, interval, cyc, idx;
      logic [N-1:0] seen_diff;
      logic [N-1:0] corner [5];

      n_checks = 0;
      n_errors = 0;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      tick();
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_borrow", 32'(borrow), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      rst = 1'b0;
      tick();

      run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
      run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
      run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
      run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

      // start while busy must be ignored
      a = 8'h10;
      b = 8'h01;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      a = 8'hFF;
      b = 8'hFF;
      start = 1'b1;
      tick();
      start = 1'b0;
      ndone = 0;
      seen_diff = '0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done) begin
            ndone++;
            seen_diff = diff;
         end
      end
      check("ignored_start_dones", ndone, 1);
      check("ignored_start_diff", 32'(seen_diff), 32'h0F);

      // reset mid-operation aborts
      a = 8'h33;
      b = 8'h11;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_diff", 32'(diff), 32'd0);
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done) ndone++;
      end
      check("abort_no_done", ndone, 0);
      run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

      // back-to-back: corner pairs first, then random operands
      corner[0] = 8'h00;
      corner[1] = 8'h01;
      corner[2] = 8'h7F;
      corner[3] = 8'h80;
      corner[4] = 8'hFF;
      for (int i = 0; i < NPAIRS; i++) begin
         if (i < 25) begin
            pa[i] = corner[i / 5];
            pb[i] = corner[i % 5];
         end else begin
            pa[i] = N'($urandom);
            pb[i] = N'($urandom);
         end
      end
      a = pa[0];
      b = pb[0];
      start = 1'b1;
      tick();
      q.push_back(0);
      cur = 1;
      a = pa[1];
      b = pb[1];
      got = 0;
      interval = 0;
      cyc = 0;
      while (got < NPAIRS && cyc < NPAIRS * 9 + 50) begin
         tick();
         cyc++;
         interval++;
         if (done) begin
            idx = q.pop_front();
            check("b2b_diff", 32'(diff), 32'(ref_diff(pa[idx], pb[idx])));
            check("b2b_borrow", 32'(borrow), 32'(ref_borrow(pa[idx], pb[idx])));
            check("b2b_ovf", 32'(ovf), 32'(ref_ovf(pa[idx], pb[idx])));
            check("b2b_interval", interval, 9);
            interval = 0;
            got++;
            if (cur < NPAIRS) begin
               q.push_back(cur);
               cur++;
               if (cur < NPAIRS) begin
                  a = pa[cur];
                  b = pb[cur];
               end else begin
                  start = 1'b0;
               end
            end
         end
      end
      start = 1'b0;
      check("b2b_result_count", got, NPAIRS);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
